// File: rtl/decoder_arbiter_if.sv
// Handshake bundle between the requesters and the round-robin grant decoder.
interface decoder_arbiter_if;
  logic [3:0] req;
  logic [1:0] grant_addr;
  logic       grant_en;
  logic [3:0] grant;
  logic       busy;

  modport master (
    output req,
    input  grant_addr,
    input  grant_en,
    input  grant,
    input  busy
  );

  modport slave (
    input  req,
    output grant_addr,
    output grant_en,
    output grant,
    output busy
  );
endinterface

// File: rtl/decoder_arbiter.sv
// Round-robin arbiter for four requesters driving a 2-to-4 decoder, with a
// per-grant hold limit and a guaranteed idle cycle between grants.
module decoder_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input logic               clk,
  input logic               reset,
  decoder_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      r_state;
  logic [1:0]  r_ptr;
  logic [7:0]  r_hold_cnt;
  logic [1:0]  r_grant_addr;
  logic        r_grant_en;
  logic [3:0]  r_grant;
  logic        r_busy;

  logic [1:0]  w_sel;
  logic [1:0]  w_idx;
  logic        w_keep;

  localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);

  function automatic logic [3:0] decode2to4(input logic [1:0] a);
    logic [3:0] d;
    case (a)
      2'd0:    d = 4'b0001;
      2'd1:    d = 4'b0010;
      2'd2:    d = 4'b0100;
      2'd3:    d = 4'b1000;
      default: d = 4'b0000;
    endcase
    return d;
  endfunction

  // Scan from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    w_sel = r_ptr;
    w_idx = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      w_idx = r_ptr + 2'(i);
      if (bus.req[w_idx]) begin
        w_sel = w_idx;
      end else begin
        w_sel = w_sel;
      end
    end
  end

  always_comb begin
    if (bus.req[r_grant_addr] && (r_hold_cnt < HOLD_LIMIT)) begin
      w_keep = 1'b1;
    end else begin
      w_keep = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ptr        <= 2'd0;
      r_hold_cnt   <= 8'd0;
      r_grant_addr <= 2'd0;
      r_grant_en   <= 1'b0;
      r_grant      <= 4'b0000;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|bus.req) begin
            r_state      <= GRANT;
            r_grant_addr <= w_sel;
            r_grant_en   <= 1'b1;
            r_grant      <= decode2to4(w_sel);
            r_busy       <= 1'b1;
            r_hold_cnt   <= 8'd1;
          end else begin
            r_state <= IDLE;
          end
        end
        GRANT: begin
          if (w_keep) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end else begin
            // Releasing always lands in IDLE, which forces the idle gap before the next grant.
            r_state    <= IDLE;
            r_grant_en <= 1'b0;
            r_grant    <= 4'b0000;
            r_busy     <= 1'b0;
            r_hold_cnt <= 8'd0;
            r_ptr      <= r_grant_addr + 2'd1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_grant_en <= 1'b0;
          r_grant    <= 4'b0000;
          r_busy     <= 1'b0;
          r_hold_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign bus.grant_addr = r_grant_addr;
  assign bus.grant_en   = r_grant_en;
  assign bus.grant      = r_grant;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_decoder_arbiter.sv
// Drives two arbiters (HOLD_MAX=8 and HOLD_MAX=1) with identical requests and
// compares them each cycle against a behavioural round-robin model.
module tb_decoder_arbiter;

  logic clk;
  logic reset;

  decoder_arbiter_if if8 ();
  decoder_arbiter_if if1 ();

  decoder_arbiter #(.HOLD_MAX(8)) dut8 (.clk(clk), .reset(reset), .bus(if8));
  decoder_arbiter #(.HOLD_MAX(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state per instance: 0 -> HOLD_MAX=8, 1 -> HOLD_MAX=1
  int hold_max [2] = '{8, 1};
  int m_en   [2];
  int m_addr [2];
  int m_cnt  [2];
  int m_ptr  [2];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_en[k] = 0; m_addr[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
    end
  endtask

  task automatic model_next(input logic [3:0] r);
    for (int k = 0; k < 2; k++) begin
      if (m_en[k] != 0) begin
        if (r[m_addr[k]] && m_cnt[k] < hold_max[k]) begin
          m_cnt[k]++;
        end else begin
          m_en[k]  = 0;
          m_cnt[k] = 0;
          m_ptr[k] = (m_addr[k] + 1) % 4;
        end
      end else if (r != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (r[(m_ptr[k] + i) % 4]) begin
            m_addr[k] = (m_ptr[k] + i) % 4;
            break;
          end
        end
        m_en[k]  = 1;
        m_cnt[k] = 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    int exp_g;
    for (int k = 0; k < 2; k++) begin
      logic [1:0] a; logic e; logic [3:0] g; logic b;
      if (k == 0) begin
        a = if8.grant_addr; e = if8.grant_en; g = if8.grant; b = if8.busy;
      end else begin
        a = if1.grant_addr; e = if1.grant_en; g = if1.grant; b = if1.busy;
      end
      exp_g = (m_en[k] != 0) ? (1 << m_addr[k]) : 0;
      check($sformatf("%s_h%0d_en", tag, hold_max[k]), int'(e), m_en[k]);
      check($sformatf("%s_h%0d_busy", tag, hold_max[k]), int'(b), m_en[k]);
      check($sformatf("%s_h%0d_grant", tag, hold_max[k]), int'(g), exp_g);
      check($sformatf("%s_h%0d_addr", tag, hold_max[k]), int'(a), m_addr[k]);
      check($sformatf("%s_h%0d_onehot", tag, hold_max[k]), int'($countones(g) <= 1), 1);
    end
  endtask

  // Apply r for one rising edge and compare on the following falling edge.
  task automatic step(input logic [3:0] r, input string tag);
    if8.req = r;
    if1.req = r;
    model_next(r);
    @(negedge clk);
    compare_all(tag);
  endtask

  // Reset pulse placed between edges; outputs must clear before any clock.
  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all("async_rst");
    check("async_rst_grant8", int'(if8.grant), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [3:0] exp27 [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                            4'b0000, 4'b1000, 4'b0000, 4'b0001};

  initial begin
    logic [3:0] r;
    reset   = 1'b1;
    if8.req = 4'b0000;
    if1.req = 4'b0000;
    model_reset();
    @(negedge clk);
    compare_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Idle with no requests
    step(4'b0000, "idle");

    // Single request then drop; ptr moves to 3
    step(4'b0100, "single");
    check("single_grant", int'(if8.grant), 4);
    check("single_addr", int'(if8.grant_addr), 2);
    check("single_busy", int'(if8.busy), 1);
    step(4'b0000, "single_drop");
    check("single_drop_grant", int'(if8.grant), 0);
    check("single_addr_kept", int'(if8.grant_addr), 2);
    step(4'b1001, "ptr3");
    check("ptr3_grant", int'(if8.grant), 8);

    // Round robin, HOLD_MAX=1
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      step(4'b1111, "rr");
      check($sformatf("rr_seq%0d", i), int'(if1.grant), int'(exp27[i]));
    end

    // Hold limit, HOLD_MAX=8
    pulse_reset();
    for (int i = 0; i < 19; i++) begin
      int exp_g;
      step(4'b0011, "hold");
      exp_g = (i < 8) ? 1 : (i == 8) ? 0 : (i < 17) ? 2 : (i == 17) ? 0 : 1;
      check($sformatf("hold_seq%0d", i), int'(if8.grant), exp_g);
    end

    // No preemption
    pulse_reset();
    step(4'b0100, "nopre");
    for (int i = 0; i < 4; i++) begin
      step(4'b0101, "nopre_hold");
      check("nopre_hold_grant", int'(if8.grant), 4);
    end
    step(4'b0001, "nopre_rel");
    check("nopre_rel_grant", int'(if8.grant), 0);
    step(4'b0001, "nopre_wrap");
    check("nopre_wrap_grant", int'(if8.grant), 1);

    // Async reset mid-grant
    pulse_reset();
    step(4'b1000, "r30");
    check("r30_pre", int'(if8.grant), 8);
    pulse_reset();
    check("r30_en", int'(if8.grant_en), 0);
    step(4'b1001, "r30_after");
    check("r30_grant", int'(if8.grant), 1);

    // Randomized traffic with occasional resets
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        pulse_reset();
      end else begin
        if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
        step(r, "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_arbiter.md
DECODER_ARBITER -- requirements
Module: decoder_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 8, maximum consecutive cycles one requester may hold the grant (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  request lines; bit i high = requester i wants the shared resource.
REQ-005 grant_addr  output  2  index of the granted requester; drives a 2-to-4 decoder address (bit0 = address0, bit1 = address1).
REQ-006 grant_en  output  1  grant valid; drives the decoder enable.
REQ-007 grant  output  4  one-hot grant, equal to the decoded form of grant_addr when grant_en=1, else 4'b0000.
REQ-008 busy  output  1  high while in state GRANT.

Function
REQ-009 All outputs shall be registered; no combinational path from req to any output.
REQ-010 The block shall implement two states: IDLE (grant_en=0) and GRANT (grant_en=1).
REQ-011 Internal pointer ptr (2 bits) shall hold the highest-priority index; search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4.
REQ-012 IDLE, req!=0 at a rising edge: select the first set bit in search order; at that edge go to GRANT with grant_addr=selected index, grant_en=1, hold_cnt=1.
REQ-013 IDLE, req==0: remain in IDLE, outputs unchanged at zero enable.
REQ-014 Grant latency shall be exactly one cycle: req sampled at edge N, grant visible after edge N.
REQ-015 GRANT, req[grant_addr]=1 and hold_cnt<HOLD_MAX: remain in GRANT, hold_cnt increments, grant_addr unchanged.
REQ-016 GRANT, req[grant_addr]=0 or hold_cnt==HOLD_MAX: release — go to IDLE, grant_en=0, grant=0, ptr=grant_addr+1 mod 4.
REQ-017 After every release exactly one cycle with grant_en=0 shall occur before any new grant (break-before-make for the gate-delay decoder).
REQ-018 Requests from other requesters during GRANT shall not preempt the current grant.
REQ-019 grant_addr shall retain its last value while grant_en=0; only grant_en and grant indicate validity.
REQ-020 hold_cnt shall be 8 bits and never exceed HOLD_MAX; HOLD_MAX=1 yields single-cycle grants.
REQ-021 A requester forced off by HOLD_MAX that keeps requesting shall be re-granted only after every other active requester has been served once.
REQ-022 grant shall always be zero or one-hot; never two bits set.

Reset
REQ-023 Asserting reset shall immediately (without a clock) force state=IDLE, grant_en=0, grant=4'b0000, busy=0, grant_addr=2'b00, ptr=2'b00, hold_cnt=0.
REQ-024 Reset asserted during GRANT shall drop the grant in the same cycle; after deassertion arbitration restarts with ptr=0.
REQ-025 First rising edge with reset low and req!=0 shall produce a grant per REQ-012.

Verification
REQ-026 Single request: reset, req=4'b0100 held -> after next edge grant_addr=2, grant=4'b0100, busy=1; req dropped -> next edge grant=0, ptr=3.
REQ-027 Round-robin: req=4'b1111 held, HOLD_MAX=1 -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001 repeating.
REQ-028 Hold limit: HOLD_MAX=8, req=4'b0011 held -> requester 0 granted 8 cycles, 1 idle cycle, requester 1 granted 8 cycles, 1 idle cycle, requester 0 again.
REQ-029 No preemption: requester 2 granted, req changes to 4'b0101 -> grant stays 4'b0100 until req[2] drops, then idle cycle, then grant=4'b0001 (ptr=3 wraps to 0).
REQ-030 Async reset mid-grant: grant=4'b1000, reset pulsed between edges -> grant=0, grant_en=0 immediately; after release with req=4'b1001 -> grant=4'b0001.
REQ-031 All scenarios: checker asserts grant one-hot-or-zero and grant==decode(grant_addr) whenever grant_en=1, every cycle.
